// File: rtl/boot_sequencer_pkg.sv
// Shared types and constants for the boot sequencer: state encoding,
// default widths and the load-count saturation helper.
package boot_sequencer_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int COUNT_WIDTH     = 11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD_DATA  = 3'd1,
        ST_LOAD_INSTR = 3'd2,
        ST_PRIME      = 3'd3,
        ST_RUN        = 3'd4,
        ST_HALTED     = 3'd5
    } seq_state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_count(
        input logic [COUNT_WIDTH-1:0] count,
        input logic [COUNT_WIDTH-1:0] limit
    );
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/boot_sequencer_load_word_counter.sv
// Word index with terminal-count compare; one instance serves both the
// data and the instruction load phases.
module load_word_counter #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             incr,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] index,
    output logic             last
);

    // Clear wins over increment so a phase change restarts at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
        end else if (clear) begin
            index <= '0;
        end else if (incr) begin
            index <= index + WIDTH'(1);
        end
    end

    assign last = ((index + WIDTH'(1)) == terminal);

endmodule

// File: rtl/boot_sequencer.sv
// Loads data then instruction BRAM from a host word stream, then primes,
// runs and halts the rv32i_sc core. All outputs are registered.
module boot_sequencer
    import boot_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] data_count,
    input  logic [COUNT_WIDTH-1:0] instr_count,
    input  logic [31:0]            run_cycles,
    input  logic                   halt_req,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic [ADDR_WIDTH-1:0]  d_w_addr,
    output logic [DATA_WIDTH-1:0]  d_w_dat,
    output logic                   d_w_enb,
    output logic [3:0]             d_w_byte_enb,
    output logic [ADDR_WIDTH-1:0]  i_w_addr,
    output logic [DATA_WIDTH-1:0]  i_w_dat,
    output logic                   i_w_enb,
    output logic [3:0]             i_w_byte_enb,
    output logic                   d_bram_init_done,
    output logic                   cpu_rst,
    output logic                   pc_stall,
    output logic                   rd_enbl,
    output logic                   i_r_enb,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state
);

    localparam logic [COUNT_WIDTH-1:0] WORD_LIMIT = COUNT_WIDTH'(DEPTH_WORDS);

    seq_state_t             state_q, state_n;
    logic [COUNT_WIDTH-1:0] data_q, data_n, instr_q, instr_n;
    logic [COUNT_WIDTH-1:0] data_sat, instr_sat, load_terminal, load_idx;
    logic [31:0]            run_q, run_n, cyc_q, cyc_n;
    logic                   load_clear, load_last, xfer, start_ok;
    logic                   d_wr, i_wr;
    logic [ADDR_WIDTH-1:0]  word_addr;
    logic                   s_ready_n, cpu_rst_n, pc_stall_n, run_en_n;
    logic                   busy_n, done_n, init_done_n;

    assign data_sat      = sat_count(data_count, WORD_LIMIT);
    assign instr_sat     = sat_count(instr_count, WORD_LIMIT);
    assign xfer          = s_valid & s_ready;
    assign d_wr          = xfer & (state_q == ST_LOAD_DATA);
    assign i_wr          = xfer & (state_q == ST_LOAD_INSTR);
    assign load_terminal = (state_q == ST_LOAD_DATA) ? data_q : instr_q;
    assign word_addr     = ADDR_WIDTH'({load_idx, 2'b00});
    assign state         = state_q;

    load_word_counter #(
        .WIDTH(COUNT_WIDTH)
    ) u_word_counter (
        .clk     (clk),
        .rst     (rst),
        .clear   (load_clear),
        .incr    (xfer),
        .terminal(load_terminal),
        .index   (load_idx),
        .last    (load_last)
    );

    // Next state plus the next value of every registered output, decoded
    // from where the sequencer will be after this edge.
    always_comb begin
        state_n    = state_q;
        data_n     = data_q;
        instr_n    = instr_q;
        run_n      = run_q;
        cyc_n      = cyc_q;
        load_clear = 1'b0;
        start_ok   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    start_ok   = 1'b1;
                    load_clear = 1'b1;
                    data_n     = data_sat;
                    instr_n    = instr_sat;
                    run_n      = run_cycles;
                    cyc_n      = '0;
                    if (data_sat != '0) begin
                        state_n = ST_LOAD_DATA;
                    end else if (instr_sat != '0) begin
                        state_n = ST_LOAD_INSTR;
                    end else begin
                        state_n = ST_PRIME;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (xfer && load_last) begin
                    load_clear = 1'b1;
                    state_n    = (instr_q != '0) ? ST_LOAD_INSTR : ST_PRIME;
                end
            end
            ST_LOAD_INSTR: begin
                if (xfer && load_last) begin
                    load_clear = 1'b1;
                    state_n    = ST_PRIME;
                end
            end
            ST_PRIME: begin
                cyc_n   = '0;
                state_n = ST_RUN;
            end
            ST_RUN: begin
                cyc_n = cyc_q + 32'd1;
                if (halt_req || ((run_q != '0) && (cyc_n == run_q))) begin
                    state_n = ST_HALTED;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        s_ready_n  = (state_n == ST_LOAD_DATA) || (state_n == ST_LOAD_INSTR);
        cpu_rst_n  = (state_n == ST_PRIME);
        pc_stall_n = (state_n != ST_RUN);
        run_en_n   = (state_n == ST_RUN);
        busy_n     = (state_n != ST_IDLE) && (state_n != ST_HALTED);
        done_n     = (state_n == ST_HALTED);

        // The datapath owns the data BRAM once data loading is over.
        init_done_n = d_bram_init_done;
        if (start_ok) begin
            init_done_n = 1'b0;
        end
        if ((state_n == ST_LOAD_INSTR) || (state_n == ST_PRIME)) begin
            init_done_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            data_q           <= '0;
            instr_q          <= '0;
            run_q            <= '0;
            cyc_q            <= '0;
            s_ready          <= 1'b0;
            d_w_addr         <= '0;
            d_w_dat          <= '0;
            d_w_enb          <= 1'b0;
            d_w_byte_enb     <= 4'h0;
            i_w_addr         <= '0;
            i_w_dat          <= '0;
            i_w_enb          <= 1'b0;
            i_w_byte_enb     <= 4'h0;
            d_bram_init_done <= 1'b0;
            cpu_rst          <= 1'b0;
            pc_stall         <= 1'b1;
            rd_enbl          <= 1'b0;
            i_r_enb          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_q          <= state_n;
            data_q           <= data_n;
            instr_q          <= instr_n;
            run_q            <= run_n;
            cyc_q            <= cyc_n;
            s_ready          <= s_ready_n;
            d_w_enb          <= d_wr;
            d_w_byte_enb     <= d_wr ? 4'hF : 4'h0;
            i_w_enb          <= i_wr;
            i_w_byte_enb     <= i_wr ? 4'hF : 4'h0;
            d_bram_init_done <= init_done_n;
            cpu_rst          <= cpu_rst_n;
            pc_stall         <= pc_stall_n;
            rd_enbl          <= run_en_n;
            i_r_enb          <= run_en_n;
            busy             <= busy_n;
            done             <= done_n;
            if (d_wr) begin
                d_w_addr <= word_addr;
                d_w_dat  <= s_data;
            end
            if (i_wr) begin
                i_w_addr <= word_addr;
                i_w_dat  <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed scenario bench for boot_sequencer; expected values are hand-derived
// from the load/prime/run/halt sequence.
module tb_boot_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] data_count = '0;
    logic [10:0] instr_count = '0;
    logic [31:0] run_cycles = '0;
    logic        halt_req = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [11:0] d_w_addr, i_w_addr;
    logic [31:0] d_w_dat, i_w_dat;
    logic        d_w_enb, i_w_enb;
    logic [3:0]  d_w_byte_enb, i_w_byte_enb;
    logic        d_bram_init_done, cpu_rst, pc_stall, rd_enbl, i_r_enb;
    logic        busy, done;
    logic [2:0]  state;

    int checks = 0;
    int passed = 0;

    logic [11:0] d_addr_log[$];
    logic [31:0] d_dat_log[$];
    logic [11:0] i_addr_log[$];
    logic [31:0] i_dat_log[$];
    int          be_err = 0;
    int          rst_pulses = 0;
    int          stall_low = 0;

    always #5 clk = ~clk;

    boot_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .data_count(data_count), .instr_count(instr_count), .run_cycles(run_cycles),
        .halt_req(halt_req), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
        .d_bram_init_done(d_bram_init_done), .cpu_rst(cpu_rst), .pc_stall(pc_stall),
        .rd_enbl(rd_enbl), .i_r_enb(i_r_enb), .busy(busy), .done(done), .state(state)
    );

    // Write-port and run-control observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (d_w_enb === 1'b1) begin
            d_addr_log.push_back(d_w_addr);
            d_dat_log.push_back(d_w_dat);
        end
        if (i_w_enb === 1'b1) begin
            i_addr_log.push_back(i_w_addr);
            i_dat_log.push_back(i_w_dat);
        end
        if (((d_w_enb === 1'b1) && (d_w_byte_enb !== 4'hF)) ||
            ((d_w_enb === 1'b0) && (d_w_byte_enb !== 4'h0)) ||
            ((i_w_enb === 1'b1) && (i_w_byte_enb !== 4'hF)) ||
            ((i_w_enb === 1'b0) && (i_w_byte_enb !== 4'h0)))
            be_err++;
        if (cpu_rst === 1'b1) rst_pulses++;
        if (pc_stall === 1'b0) stall_low++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        d_addr_log.delete();
        d_dat_log.delete();
        i_addr_log.delete();
        i_dat_log.delete();
        be_err = 0;
        rst_pulses = 0;
        stall_low = 0;
    endtask

    task automatic pulse_start(input int dc, input int ic, input int rc);
        data_count = 11'(dc);
        instr_count = 11'(ic);
        run_cycles = 32'(rc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams n_data data words then n_instr instruction words; bp gives a 1,0,0 valid pattern.
    task automatic feed(input int n_data, input int n_instr, input bit bp);
        int  k = 0;
        int  cyc = 0;
        int  total = n_data + n_instr;
        bit  acc;
        while (k < total && cyc < 5000) begin
            s_valid = bp ? (cyc % 3 == 0) : 1'b1;
            s_data = (k < n_data) ? 32'hD000_0000 + 32'(k) : 32'hA000_0000 + 32'(k - n_data);
            @(negedge clk);
            acc = s_valid && s_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        s_valid = 1'b0;
        checks++;
        if (k != total) $display("[TB] FAIL feed_timeout: accepted %0d words, required %0d", k, total);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({state, s_ready, pc_stall, busy, done, cpu_rst, rd_enbl, i_r_enb, d_w_enb, i_w_enb, d_bram_init_done}
            !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("[TB] FAIL reset_values: state=%0d s_ready=%b pc_stall=%b busy=%b done=%b cpu_rst=%b rd=%b ir=%b",
                     state, s_ready, pc_stall, busy, done, cpu_rst, rd_enbl, i_r_enb);
        else passed++;
        rst = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || s_ready !== 1'b0) $display("[TB] FAIL idle_after_reset: state=%0d s_ready=%b, required 0/0", state, s_ready);
        else passed++;
    endtask

    task automatic test_load_run();
        bit ok = 1'b1;
        int bad = -1;
        clear_log();
        pulse_start(3, 4, 20);
        checks++;
        if (state !== 3'd1 || s_ready !== 1'b1 || busy !== 1'b1 || d_bram_init_done !== 1'b0)
            $display("[TB] FAIL start_to_load: state=%0d s_ready=%b busy=%b init=%b, required 1/1/1/0", state, s_ready, busy, d_bram_init_done);
        else passed++;
        feed(3, 4, 1'b0);
        checks++;
        if (state !== 3'd3 || cpu_rst !== 1'b1 || pc_stall !== 1'b1 || s_ready !== 1'b0 || d_bram_init_done !== 1'b1)
            $display("[TB] FAIL prime_entry: state=%0d cpu_rst=%b pc_stall=%b s_ready=%b init=%b", state, cpu_rst, pc_stall, s_ready, d_bram_init_done);
        else passed++;
        for (int n = 0; n < 100 && done !== 1'b1; n++) tick();
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || state !== 3'd5 || rd_enbl !== 1'b0 || i_r_enb !== 1'b0 || pc_stall !== 1'b1)
            $display("[TB] FAIL halted_outputs: done=%b busy=%b state=%0d rd=%b ir=%b pc_stall=%b", done, busy, state, rd_enbl, i_r_enb, pc_stall);
        else passed++;
        checks++;
        if (stall_low != 20) $display("[TB] FAIL run_length: pc_stall low %0d cycles, required 20", stall_low);
        else passed++;
        checks++;
        if (rst_pulses != 1) $display("[TB] FAIL cpu_rst_pulse: %0d cycles high, required 1", rst_pulses);
        else passed++;
        for (int j = 0; j < 3; j++)
            if (j >= d_addr_log.size() || d_addr_log[j] !== 12'(j * 4) || d_dat_log[j] !== 32'hD000_0000 + 32'(j)) begin
                ok = 1'b0;
                if (bad < 0) bad = j;
            end
        checks++;
        if (!ok || d_addr_log.size() != 3) $display("[TB] FAIL d_writes: %0d writes, first bad index %0d, required 3 writes at 0x0/0x4/0x8", d_addr_log.size(), bad);
        else passed++;
        ok = 1'b1;
        bad = -1;
        for (int j = 0; j < 4; j++)
            if (j >= i_addr_log.size() || i_addr_log[j] !== 12'(j * 4) || i_dat_log[j] !== 32'hA000_0000 + 32'(j)) begin
                ok = 1'b0;
                if (bad < 0) bad = j;
            end
        checks++;
        if (!ok || i_addr_log.size() != 4) $display("[TB] FAIL i_writes: %0d writes, first bad index %0d, required 4 writes at 0x0..0xC", i_addr_log.size(), bad);
        else passed++;
        checks++;
        if (be_err != 0) $display("[TB] FAIL byte_enables: %0d bad cycles, required 0", be_err);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit ok = 1'b1;
        int bad = -1;
        clear_log();
        pulse_start(4, 3, 5);
        feed(4, 3, 1'b1);
        for (int n = 0; n < 100 && done !== 1'b1; n++) tick();
        checks++;
        if (done !== 1'b1 || stall_low != 5) $display("[TB] FAIL bp_run: done=%b stall_low=%0d, required 1/5", done, stall_low);
        else passed++;
        for (int j = 0; j < 4; j++)
            if (j >= d_addr_log.size() || d_addr_log[j] !== 12'(j * 4) || d_dat_log[j] !== 32'hD000_0000 + 32'(j)) begin
                ok = 1'b0;
                if (bad < 0) bad = j;
            end
        for (int j = 0; j < 3; j++)
            if (j >= i_addr_log.size() || i_addr_log[j] !== 12'(j * 4) || i_dat_log[j] !== 32'hA000_0000 + 32'(j)) begin
                ok = 1'b0;
                if (bad < 0) bad = 10 + j;
            end
        checks++;
        if (!ok || d_addr_log.size() != 4 || i_addr_log.size() != 3 || be_err != 0)
            $display("[TB] FAIL bp_writes: d=%0d i=%0d be_err=%0d bad=%0d, required d=4 i=3 be_err=0", d_addr_log.size(), i_addr_log.size(), be_err, bad);
        else passed++;
    endtask

    task automatic test_zero_counts_halt();
        clear_log();
        pulse_start(0, 0, 0);
        checks++;
        if (state !== 3'd3 || cpu_rst !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL zero_prime: state=%0d cpu_rst=%b s_ready=%b done=%b busy=%b", state, cpu_rst, s_ready, done, busy);
        else passed++;
        tick();
        checks++;
        if (state !== 3'd4 || pc_stall !== 1'b0 || rd_enbl !== 1'b1 || i_r_enb !== 1'b1)
            $display("[TB] FAIL zero_run_entry: state=%0d pc_stall=%b rd=%b ir=%b", state, pc_stall, rd_enbl, i_r_enb);
        else passed++;
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (state !== 3'd4) $display("[TB] FAIL unbounded_run: state=%0d after 6 cycles, required 4", state);
        else passed++;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (state !== 3'd5 || pc_stall !== 1'b1 || done !== 1'b1)
            $display("[TB] FAIL halt_req: state=%0d pc_stall=%b done=%b, required 5/1/1", state, pc_stall, done);
        else passed++;
        checks++;
        if (stall_low != 7 || d_addr_log.size() != 0 || i_addr_log.size() != 0)
            $display("[TB] FAIL halt_length: stall_low=%0d d=%0d i=%0d, required 7/0/0", stall_low, d_addr_log.size(), i_addr_log.size());
        else passed++;
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start(2, 3, 4);
        feed(2, 0, 1'b0);
        pulse_start(5, 7, 9);
        checks++;
        if (state !== 3'd2 || busy !== 1'b1 || d_bram_init_done !== 1'b1)
            $display("[TB] FAIL start_in_load: state=%0d busy=%b init=%b, required 2/1/1", state, busy, d_bram_init_done);
        else passed++;
        feed(0, 3, 1'b0);
        checks++;
        if (state !== 3'd3) $display("[TB] FAIL instr_count_kept: state=%0d after 3 words, required 3", state);
        else passed++;
        for (int n = 0; n < 100 && done !== 1'b1; n++) tick();
        checks++;
        if (done !== 1'b1 || stall_low != 4 || i_addr_log.size() != 3 || d_addr_log.size() != 2 || i_addr_log[2] !== 12'h008)
            $display("[TB] FAIL start_ignored_run: done=%b stall_low=%0d i=%0d d=%0d, required 1/4/3/2", done, stall_low, i_addr_log.size(), d_addr_log.size());
        else passed++;
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start(5, 2, 10);
        feed(2, 0, 1'b0);
        s_valid = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if ({state, s_ready, pc_stall, busy, done, cpu_rst, rd_enbl, d_w_enb, d_w_byte_enb, d_w_addr, d_bram_init_done}
            !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0})
            $display("[TB] FAIL reset_mid_load: state=%0d s_ready=%b pc_stall=%b busy=%b d_w_enb=%b be=%h addr=%h",
                     state, s_ready, pc_stall, busy, d_w_enb, d_w_byte_enb, d_w_addr);
        else passed++;
        rst = 1'b0;
        tick();
        s_valid = 1'b0;
        checks++;
        if (state !== 3'd0 || s_ready !== 1'b0 || d_addr_log.size() != 2)
            $display("[TB] FAIL idle_after_mid_reset: state=%0d s_ready=%b d=%0d, required 0/0/2", state, s_ready, d_addr_log.size());
        else passed++;
    endtask

    task automatic test_saturation();
        clear_log();
        pulse_start(2000, 0, 3);
        feed(1024, 0, 1'b0);
        checks++;
        if (state !== 3'd3) $display("[TB] FAIL saturate_phase_end: state=%0d after 1024 words, required 3", state);
        else passed++;
        for (int n = 0; n < 100 && done !== 1'b1; n++) tick();
        checks++;
        if (d_addr_log.size() != 1024 || d_addr_log[d_addr_log.size() - 1] !== 12'hFFC ||
            d_dat_log[d_dat_log.size() - 1] !== 32'hD000_03FF)
            $display("[TB] FAIL saturate_writes: %0d writes, required 1024 ending at 0xFFC", d_addr_log.size());
        else passed++;
        checks++;
        if (done !== 1'b1 || stall_low != 3 || i_addr_log.size() != 0)
            $display("[TB] FAIL saturate_run: done=%b stall_low=%0d i=%0d, required 1/3/0", done, stall_low, i_addr_log.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_backpressure();
        test_zero_counts_halt();
        test_start_ignored();
        test_reset_mid_load();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Sequences the rv32i_sc single-core datapath from power-up to execution. Accepts a host word stream over a valid/ready handshake and writes it into data BRAM, then instruction BRAM, at 4-byte-aligned addresses. It then pulses the CPU reset, releases the PC stall and the read enables for a bounded or unbounded run, and finally halts the core. It replaces hand-sequenced loading in system benches and the board top level, and sits between the host/UART interface and the two `bram32` write ports plus the `pc` and `register_file` controls.

## Interface
- `DATA_WIDTH`, 32: stream word and BRAM data width.
- `ADDR_WIDTH`, 12: BRAM byte-address width.
- `DEPTH_WORDS`, 1024: maximum words per BRAM.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high.
- `start` in 1: begin a load/run sequence; sampled only in IDLE or HALTED.
- `data_count` in 11: data words to load; latched on accepted `start`.
- `instr_count` in 11: instruction words to load; latched on accepted `start`.
- `run_cycles` in 32: RUN length in cycles; 0 means run until `halt_req`. Latched on accepted `start`.
- `halt_req` in 1: stop execution; effective in RUN only.
- `s_valid` in 1, `s_ready` out 1, `s_data` in DATA_WIDTH: host word stream.
- `d_w_addr` out ADDR_WIDTH, `d_w_dat` out DATA_WIDTH, `d_w_enb` out 1, `d_w_byte_enb` out 4: data BRAM load port.
- `i_w_addr`, `i_w_dat`, `i_w_enb`, `i_w_byte_enb`: instruction BRAM load port; widths as above.
- `d_bram_init_done` out 1: hands the data BRAM write mux to the datapath.
- `cpu_rst` out 1: reset pulse to `pc` and `register_file`.
- `pc_stall`, `rd_enbl`, `i_r_enb` out 1: core run controls.
- `busy` out 1, `done` out 1, `state` out 3.

## Operation
- States are IDLE, LOAD_DATA, LOAD_INSTR, PRIME, RUN and HALTED. All outputs are registered.
- Reset values: all outputs 0 except `pc_stall` = 1; `state` = IDLE; counters = 0.
- **IDLE or HALTED with `start`:**
  - Latch the three count/length inputs.
  - Counts above DEPTH_WORDS saturate to DEPTH_WORDS.
  - Clear `done` and `d_bram_init_done`; set `busy`.
  - Go to LOAD_DATA, or to LOAD_INSTR if `data_count` = 0, or to PRIME if both counts = 0.
- **LOAD_DATA:**
  - `s_ready` = 1. Each transfer (`s_valid` & `s_ready`) with word index k produces `d_w_enb` = 1, `d_w_byte_enb` = 4'b1111, `d_w_addr` = k·4 and `d_w_dat` = `s_data` on the next cycle.
  - When no write is issued, `d_w_enb` = 0 and byte enables are 0000.
  - After the last word is accepted, go to LOAD_INSTR (or PRIME if `instr_count` = 0).
- **LOAD_INSTR:** same behaviour on the `i_w_*` port; the index restarts at 0. `d_bram_init_done` = 1 from entry and stays 1 until the next accepted `start`.
- **PRIME:** one cycle. `cpu_rst` = 1, `pc_stall` = 1, `s_ready` = 0.
- **RUN:**
  - `pc_stall` = 0, `rd_enbl` = 1, `i_r_enb` = 1.
  - The cycle counter increments each RUN cycle. Leave when the count reaches `run_cycles` (nonzero) or when `halt_req` = 1; `halt_req` has priority and both give the same result.
- **HALTED:** `pc_stall` = 1, `rd_enbl` = 0, `i_r_enb` = 0, `done` = 1, `busy` = 0. Register and BRAM contents are untouched.
- Outside LOAD states, `s_ready` = 0 and `s_valid` is ignored.
- `start` in any busy state is ignored.
- `rst` mid-sequence: IDLE next cycle with reset values. Partial BRAM contents remain.

## Timing
- Load throughput is one word per cycle when `s_valid` is held high.
- BRAM write strobe latency is 1 cycle after the accepted transfer.
- `s_ready` drops in the cycle after the last accepted word of the final load phase. The last write strobe coincides with entry to the next state.
- `start` → first `s_ready` = 1 cycle.
- Last instruction word accepted → PRIME next cycle → RUN the following cycle.
- With `run_cycles` = N, `pc_stall` is low for exactly N consecutive cycles.
- `halt_req` sampled high in RUN → `pc_stall` = 1 on the next cycle.

## Structure
- State encodings (3-bit) and `DEPTH_WORDS` go in a new shared include, `rv32i_loader.vh`, alongside `rv32i_params.vh`.
- One natural sub-module: `load_word_counter`. It is a reusable word index plus terminal-count compare with clear/increment, instantiated once and shared by both load phases.

## Test plan
- `data_count` = 3, `instr_count` = 4, `run_cycles` = 20, continuous valid → D writes at 0x0/0x4/0x8, then I writes at 0x0–0xC.
  - `cpu_rst` pulses once.
  - `pc_stall` is low for exactly 20 cycles, then `done` = 1.
- Backpressure: `s_valid` toggles 1,0,0,1,… → every write address is correct, with no duplicate or skipped indices.
- Counts 0/0 → IDLE, then PRIME, then RUN with no writes. `run_cycles` = 0 plus `halt_req` at cycle 7 → halts after 7 RUN cycles.
- `start` asserted during LOAD_INSTR → ignored; counts are unchanged.
- `rst` asserted mid-LOAD_DATA (after 2 words) → next cycle all outputs are at reset values, `state` = IDLE and `s_ready` = 0.
- `data_count` = 2000 → saturates; exactly 1024 writes, last address 0xFFC.
